// File: rtl/denise_sprite_channel.sv
// One Denise hardware-sprite channel: position/control/data registers,
// horizontal comparator and a 16-pixel, 2-bitplane serialiser.
module denise_sprite_channel #(
  parameter logic [8:0] BASE = 9'h140
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk7_en,
  input  logic [8:1]  reg_address_in,
  input  logic [15:0] data_in,
  input  logic [8:0]  hpos,
  output logic [1:0]  sprdata,
  output logic        nsprite,
  output logic        attach,
  output logic        active
);

  localparam logic [8:0] POS_ADDR  = BASE;
  localparam logic [8:0] CTL_ADDR  = BASE + 9'd2;
  localparam logic [8:0] DATA_ADDR = BASE + 9'd4;
  localparam logic [8:0] DATB_ADDR = BASE + 9'd6;

  logic [8:0]  r_hstart;
  logic [15:0] r_datla;
  logic [15:0] r_datlb;
  logic        r_attach;
  logic        r_armed;
  logic [15:0] r_shifta;
  logic [15:0] r_shiftb;
  logic [4:0]  r_count;

  logic w_posWr;
  logic w_ctlWr;
  logic w_dataWr;
  logic w_datbWr;
  logic w_match;

  assign w_posWr  = (reg_address_in == POS_ADDR[8:1]);
  assign w_ctlWr  = (reg_address_in == CTL_ADDR[8:1]);
  assign w_dataWr = (reg_address_in == DATA_ADDR[8:1]);
  assign w_datbWr = (reg_address_in == DATB_ADDR[8:1]);

  // Comparator sees the registers as they were before any write in this cycle.
  assign w_match = r_armed && (hpos == r_hstart);

  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        r_hstart <= 9'd0;
        r_datla  <= 16'd0;
        r_datlb  <= 16'd0;
        r_attach <= 1'b0;
        r_armed  <= 1'b0;
      end else begin
        if (w_posWr) begin
          r_hstart[8:1] <= data_in[7:0];
        end
        if (w_ctlWr) begin
          r_hstart[0] <= data_in[0];
          r_attach    <= data_in[7];
          r_armed     <= 1'b0;
        end
        if (w_dataWr) begin
          r_datla <= data_in;
          r_armed <= 1'b1;
        end
        if (w_datbWr) begin
          r_datlb <= data_in;
        end
      end
    end
  end

  // A match always wins, so a retrigger mid-burst restarts from pixel 0.
  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (reset) begin
        r_shifta <= 16'd0;
        r_shiftb <= 16'd0;
        r_count  <= 5'd0;
      end else if (w_match) begin
        r_shifta <= r_datla;
        r_shiftb <= r_datlb;
        r_count  <= 5'd16;
      end else if (r_count != 5'd0) begin
        r_shifta <= {r_shifta[14:0], 1'b0};
        r_shiftb <= {r_shiftb[14:0], 1'b0};
        r_count  <= r_count - 5'd1;
      end
    end
  end

  assign sprdata = {r_shiftb[15], r_shifta[15]};
  assign nsprite = |sprdata;
  assign attach  = r_attach;
  assign active  = (r_count != 5'd0);

endmodule

// File: tb/tb_denise_sprite_channel.sv
// Self-checking bench for denise_sprite_channel: constant vector table,
// directed corner sequences and a randomized run against a pixel-index model.
module tb_denise_sprite_channel;

  localparam logic [7:0] A_POS  = 8'hA0;
  localparam logic [7:0] A_CTL  = 8'hA1;
  localparam logic [7:0] A_DATA = 8'hA2;
  localparam logic [7:0] A_DATB = 8'hA3;
  localparam logic [7:0] A_IDLE = 8'h00;
  localparam logic [8:0] H_PARK = 9'h1F0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk7_en = 1'b0;
  logic [7:0]  reg_address_in = A_IDLE;
  logic [15:0] data_in = 16'd0;
  logic [8:0]  hpos = 9'd0;
  logic [1:0]  sprdata;
  logic        nsprite;
  logic        attach;
  logic        active;

  int checks = 0;
  int errors = 0;

  // Model: a burst is "which pixel index k of the latched pattern is showing".
  logic [8:0]  mHstart = 9'd0;
  logic [15:0] mDatla = 16'd0;
  logic [15:0] mDatlb = 16'd0;
  logic        mAttach = 1'b0;
  logic        mArmed = 1'b0;
  logic [15:0] mPa = 16'd0;
  logic [15:0] mPb = 16'd0;
  int          mK = 16;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    logic [8:0]  hp;
    logic        rst;
    logic [1:0]  expSpr;
    logic        expAct;
    logic        expAtt;
  } vec_t;

  vec_t vecs[23];

  denise_sprite_channel #(.BASE(9'h140)) dut (
    .clk(clk),
    .reset(reset),
    .clk7_en(clk7_en),
    .reg_address_in(reg_address_in),
    .data_in(data_in),
    .hpos(hpos),
    .sprdata(sprdata),
    .nsprite(nsprite),
    .attach(attach),
    .active(active)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [1:0] modelSpr();
    if (mK < 16) return {mPb[15-mK], mPa[15-mK]};
    return 2'b00;
  endfunction

  task automatic modelStep(input logic [7:0] addr, input logic [15:0] data,
                           input logic [8:0] hp, input logic rst);
    logic match;
    if (rst) begin
      mHstart = 9'd0; mDatla = 16'd0; mDatlb = 16'd0;
      mAttach = 1'b0; mArmed = 1'b0; mPa = 16'd0; mPb = 16'd0; mK = 16;
    end else begin
      match = mArmed && (hp == mHstart);
      if (match) begin
        mPa = mDatla; mPb = mDatlb; mK = 0;
      end else if (mK < 16) begin
        mK++;
      end
      case (addr)
        A_POS:  mHstart[8:1] = data[7:0];
        A_CTL:  begin mHstart[0] = data[0]; mAttach = data[7]; mArmed = 1'b0; end
        A_DATA: begin mDatla = data; mArmed = 1'b1; end
        A_DATB: mDatlb = data;
        default: ;
      endcase
    end
  endtask

  // One clk7_en pulse; outputs are sampled three non-enable edges later so holding is tested too.
  task automatic applyStimulus(input logic [7:0] addr, input logic [15:0] data,
                               input logic [8:0] hp, input logic rst);
    @(negedge clk);
    reg_address_in = addr; data_in = data; hpos = hp; reset = rst; clk7_en = 1'b1;
    @(posedge clk);
    #1;
    clk7_en = 1'b0; reset = 1'b0; reg_address_in = A_IDLE;
    repeat (3) @(posedge clk);
    #1;
    modelStep(addr, data, hp, rst);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [15:0] data);
    applyStimulus(addr, data, H_PARK, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [1:0] eSpr,
                             input logic eAct, input logic eAtt);
    cmp({name, " sprdata"}, {14'd0, sprdata}, {14'd0, eSpr});
    cmp({name, " nsprite"}, {15'd0, nsprite}, {15'd0, |eSpr});
    cmp({name, " attach"},  {15'd0, attach},  {15'd0, eAtt});
    cmp({name, " active"},  {15'd0, active},  {15'd0, eAct});
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, modelSpr(), (mK < 16), mAttach);
  endtask

  initial begin
    vecs[0] = '{A_POS,  16'h0040, 9'h000, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[1] = '{A_CTL,  16'h0000, 9'h000, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[2] = '{A_DATA, 16'h8001, 9'h000, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[3] = '{A_DATB, 16'hC000, 9'h000, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[4] = '{A_IDLE, 16'h0000, 9'h07F, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[5] = '{A_IDLE, 16'h0000, 9'h080, 1'b0, 2'd3, 1'b1, 1'b0};
    vecs[6] = '{A_IDLE, 16'h0000, 9'h081, 1'b0, 2'd2, 1'b1, 1'b0};
    for (int i = 0; i < 13; i++)
      vecs[7+i] = '{A_IDLE, 16'h0000, 9'h082 + 9'(i), 1'b0, 2'd0, 1'b1, 1'b0};
    vecs[20] = '{A_IDLE, 16'h0000, 9'h08F, 1'b0, 2'd1, 1'b1, 1'b0};
    vecs[21] = '{A_IDLE, 16'h0000, 9'h090, 1'b0, 2'd0, 1'b0, 1'b0};
    vecs[22] = '{A_IDLE, 16'h0000, 9'h091, 1'b0, 2'd0, 1'b0, 1'b0};

    // Reset, then a write that arms, then reset again: nothing may fire on any hpos.
    applyStimulus(A_IDLE, 16'd0, 9'd0, 1'b1);
    checkOutput("reset", 2'd0, 1'b0, 1'b0);
    wr(A_CTL, 16'h0080);
    wr(A_DATA, 16'hFFFF);
    cmp("attach before reset", {15'd0, attach}, 16'd1);
    applyStimulus(A_IDLE, 16'd0, 9'd0, 1'b1);
    checkOutput("reset2", 2'd0, 1'b0, 1'b0);
    for (int h = 0; h < 512; h++) begin
      applyStimulus(A_IDLE, 16'd0, 9'(h), 1'b0);
      cmp($sformatf("sweep nsprite h%0h", h), {15'd0, nsprite}, 16'd0);
    end

    for (int i = 0; i < 23; i++) begin
      applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].hp, vecs[i].rst);
      checkOutput($sformatf("vec%0d", i), vecs[i].expSpr, vecs[i].expAct, vecs[i].expAtt);
    end

    // Disarm via CTL, then re-arm via DATA.
    wr(A_CTL, 16'h0000);
    for (int h = 9'h07E; h <= 9'h092; h++) begin
      applyStimulus(A_IDLE, 16'd0, 9'(h), 1'b0);
      cmp($sformatf("disarm active h%0h", h), {15'd0, active}, 16'd0);
    end
    wr(A_DATA, 16'h8001);
    applyStimulus(A_IDLE, 16'd0, 9'h080, 1'b0);
    checkOutput("rearm", 2'd3, 1'b1, 1'b0);
    for (int h = 9'h081; h <= 9'h091; h++) begin
      applyStimulus(A_IDLE, 16'd0, 9'(h), 1'b0);
      checkModel($sformatf("rearm h%0h", h));
    end

    // Retrigger mid-burst: hstart 0x81 -> 0x85 with a single POS write.
    wr(A_POS, 16'h0040);
    wr(A_CTL, 16'h0001);
    wr(A_DATA, 16'hAAAA);
    wr(A_DATB, 16'hF000);
    applyStimulus(A_IDLE, 16'd0, 9'h081, 1'b0);
    checkOutput("retrig p0", 2'd3, 1'b1, 1'b0);
    applyStimulus(A_POS, 16'h0042, 9'h082, 1'b0);
    checkOutput("retrig p1", 2'd2, 1'b1, 1'b0);
    for (int h = 9'h083; h <= 9'h096; h++) begin
      applyStimulus(A_IDLE, 16'd0, 9'(h), 1'b0);
      checkModel($sformatf("retrig h%0h", h));
      if (h == 9'h085) checkOutput("retrig restart", 2'd3, 1'b1, 1'b0);
      if (h == 9'h094) cmp("retrig last active", {15'd0, active}, 16'd1);
      if (h == 9'h095) cmp("retrig end", {15'd0, active}, 16'd0);
    end

    // DATA write in the match cycle: old pattern shown now, new one on the next line.
    wr(A_POS, 16'h0040);
    wr(A_CTL, 16'h0000);
    wr(A_DATA, 16'h0001);
    wr(A_DATB, 16'h0000);
    applyStimulus(A_DATA, 16'hFFFF, 9'h080, 1'b0);
    checkOutput("samecyc p0", 2'd0, 1'b1, 1'b0);
    for (int h = 9'h081; h <= 9'h09F; h++) begin
      applyStimulus(A_IDLE, 16'd0, 9'(h), 1'b0);
      checkModel($sformatf("samecyc h%0h", h));
      if (h == 9'h08F) checkOutput("samecyc p15", 2'd1, 1'b1, 1'b0);
    end
    applyStimulus(A_IDLE, 16'd0, 9'h080, 1'b0);
    checkOutput("nextline p0", 2'd1, 1'b1, 1'b0);
    for (int h = 9'h081; h <= 9'h090; h++) begin
      applyStimulus(A_IDLE, 16'd0, 9'(h), 1'b0);
      checkModel($sformatf("nextline h%0h", h));
    end

    // CTL write in the match cycle: burst still loads, but no burst on the next line.
    applyStimulus(A_CTL, 16'h0000, 9'h080, 1'b0);
    checkOutput("ctlmatch", 2'd1, 1'b1, 1'b0);
    for (int h = 9'h081; h <= 9'h090; h++) begin
      applyStimulus(A_IDLE, 16'd0, 9'(h), 1'b0);
      checkModel($sformatf("ctlmatch h%0h", h));
    end
    for (int h = 9'h07F; h <= 9'h082; h++) begin
      applyStimulus(A_IDLE, 16'd0, 9'(h), 1'b0);
      cmp($sformatf("ctlmatch nextline h%0h", h), {15'd0, active}, 16'd0);
    end

    // Attach and odd hstart.
    wr(A_POS, 16'h0040);
    wr(A_CTL, 16'h0081);
    wr(A_DATA, 16'hFFFF);
    cmp("attach set", {15'd0, attach}, 16'd1);
    applyStimulus(A_IDLE, 16'd0, 9'h080, 1'b0);
    checkOutput("odd h80", 2'd0, 1'b0, 1'b1);
    applyStimulus(A_IDLE, 16'd0, 9'h081, 1'b0);
    checkOutput("odd h81", 2'd1, 1'b1, 1'b1);

    // Reset mid-burst.
    applyStimulus(A_IDLE, 16'd0, 9'h082, 1'b0);
    applyStimulus(A_IDLE, 16'd0, 9'h083, 1'b1);
    checkOutput("reset midburst", 2'd0, 1'b0, 1'b0);
    applyStimulus(A_IDLE, 16'd0, 9'h081, 1'b0);
    checkOutput("after reset", 2'd0, 1'b0, 1'b0);

    // Randomized traffic in a small hpos window so matches and retriggers are frequent.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0]  addr;
      logic [15:0] data;
      logic        rst;
      int          sel;
      sel  = $urandom_range(0, 9);
      data = 16'($urandom);
      case (sel)
        0: begin addr = A_POS; data[7:0] = 8'($urandom_range(0, 15)); end
        1: addr = A_CTL;
        2: addr = A_DATA;
        3: addr = A_DATB;
        default: addr = A_IDLE;
      endcase
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus(addr, data, 9'($urandom_range(0, 31)), rst);
      checkModel($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
